// File: rtl/ldpc_enc_ctrl_pkg.sv
// Shared constants and state encoding for the LDPC encoder frame sequencer.
package ldpc_enc_ctrl_pkg;

  localparam int unsigned K_BITS     = 4320;
  localparam int unsigned GROUP      = 360;
  localparam int unsigned CLR_CYCLES = 3;
  localparam int unsigned CNT_W      = 13;
  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned CLR_W      = $clog2(CLR_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_PARK = CNT_W'(K_BITS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(K_BITS - 1);
  localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(GROUP - 1);
  localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_LOAD   = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

endpackage

// File: rtl/ldpc_enc_ctrl.sv
// Frame sequencer: clears the encoder, streams 4320 info bits into it, then
// sweeps parity addresses 359..0 and merges both phases onto one serial output.
module ldpc_enc_ctrl
  import ldpc_enc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic              s_data,
  output logic              s_ready,
  output logic              enc_rst_n,
  output logic              enc_din_valid,
  output logic              enc_din,
  output logic [CNT_W-1:0]  enc_counter,
  output logic [ADDR_W-1:0] enc_out_addr,
  output logic              enc_data_valid_check,
  input  logic              enc_dout,
  output logic              m_valid,
  output logic              m_data,
  output logic              m_sof,
  output logic              m_eof,
  output logic              frame_done
);

  state_e              r_state,      w_state_nxt;
  logic [CLR_W-1:0]    r_clr_cnt,    w_clr_cnt_nxt;
  logic [CNT_W-1:0]    r_bit_idx,    w_bit_idx_nxt;
  logic                r_s_ready,    w_s_ready_nxt;
  logic                r_enc_rst_n,  w_enc_rst_n_nxt;
  logic                r_din_valid,  w_din_valid_nxt;
  logic                r_din,        w_din_nxt;
  logic [CNT_W-1:0]    r_counter,    w_counter_nxt;
  logic [ADDR_W-1:0]   r_addr,       w_addr_nxt;
  logic                r_check,      w_check_nxt;
  logic                r_par_valid,  w_par_valid_nxt;
  logic                r_sof,        w_sof_nxt;
  logic                r_last,       w_last_nxt;
  logic                w_accept;

  assign w_accept = s_valid & r_s_ready;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_CLEAR;
      r_clr_cnt   <= '0;
      r_bit_idx   <= '0;
      r_s_ready   <= 1'b0;
      r_enc_rst_n <= 1'b0;
      r_din_valid <= 1'b0;
      r_din       <= 1'b0;
      r_counter   <= '0;
      r_addr      <= '0;
      r_check     <= 1'b0;
      r_par_valid <= 1'b0;
      r_sof       <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_cnt   <= w_clr_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_s_ready   <= w_s_ready_nxt;
      r_enc_rst_n <= w_enc_rst_n_nxt;
      r_din_valid <= w_din_valid_nxt;
      r_din       <= w_din_nxt;
      r_counter   <= w_counter_nxt;
      r_addr      <= w_addr_nxt;
      r_check     <= w_check_nxt;
      r_par_valid <= w_par_valid_nxt;
      r_sof       <= w_sof_nxt;
      r_last      <= w_last_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_clr_cnt_nxt   = r_clr_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_s_ready_nxt   = 1'b0;
    w_enc_rst_n_nxt = 1'b1;
    w_din_valid_nxt = 1'b0;
    w_din_nxt       = r_din;
    w_counter_nxt   = r_counter;
    w_addr_nxt      = '0;
    w_check_nxt     = 1'b0;
    w_sof_nxt       = 1'b0;
    // parity read data arrives one cycle after its address
    w_par_valid_nxt = r_check;
    w_last_nxt      = r_check & (r_addr == '0);

    unique case (r_state)
      ST_CLEAR: begin
        w_counter_nxt = '0;
        w_bit_idx_nxt = '0;
        if (r_clr_cnt == CLR_LAST) begin
          w_state_nxt   = ST_LOAD;
          w_clr_cnt_nxt = '0;
          w_s_ready_nxt = 1'b1;
        end else begin
          w_clr_cnt_nxt   = r_clr_cnt + CLR_W'(1);
          w_enc_rst_n_nxt = 1'b0;
        end
      end

      ST_LOAD: begin
        w_s_ready_nxt = 1'b1;
        if (w_accept) begin
          w_din_valid_nxt = 1'b1;
          w_din_nxt       = s_data;
          w_counter_nxt   = r_bit_idx;
          w_sof_nxt       = (r_bit_idx == '0);
          w_bit_idx_nxt   = r_bit_idx + CNT_W'(1);
          if (r_bit_idx == CNT_LAST) begin
            w_state_nxt   = ST_PARITY;
            w_s_ready_nxt = 1'b0;
          end
        end
      end

      ST_PARITY: begin
        // parked index keeps the encoder's finish detection to a single pulse
        w_counter_nxt = CNT_PARK;
        if (!r_check) begin
          w_check_nxt = 1'b1;
          w_addr_nxt  = ADDR_TOP;
        end else if (r_addr != '0) begin
          w_check_nxt = 1'b1;
          w_addr_nxt  = r_addr - ADDR_W'(1);
        end else begin
          w_state_nxt     = ST_CLEAR;
          w_clr_cnt_nxt   = '0;
          w_enc_rst_n_nxt = 1'b0;
          w_counter_nxt   = '0;
        end
      end

      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  assign s_ready              = r_s_ready;
  assign enc_rst_n            = r_enc_rst_n;
  assign enc_din_valid        = r_din_valid;
  assign enc_din              = r_din;
  assign enc_counter          = r_counter;
  assign enc_out_addr         = r_addr;
  assign enc_data_valid_check = r_check;

  // Systematic and parity phases never overlap, so a plain merge suffices
  assign m_valid    = r_din_valid | r_par_valid;
  assign m_data     = r_par_valid ? enc_dout : (r_din_valid & r_din);
  assign m_sof      = r_sof;
  assign m_eof      = r_last;
  assign frame_done = r_last;

endmodule

// File: tb/tb_ldpc_enc_ctrl.sv
// Bench for ldpc_enc_ctrl with a behavioural parity-accumulator encoder stub
// and a queue of expected output beats.
module tb_ldpc_enc_ctrl;
  import ldpc_enc_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_data;
  logic              s_ready;
  logic              enc_rst_n;
  logic              enc_din_valid;
  logic              enc_din;
  logic [CNT_W-1:0]  enc_counter;
  logic [ADDR_W-1:0] enc_out_addr;
  logic              enc_data_valid_check;
  logic              enc_dout = 1'b0;
  logic              m_valid;
  logic              m_data;
  logic              m_sof;
  logic              m_eof;
  logic              frame_done;

  always #5 clk = ~clk;

  ldpc_enc_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_valid              (s_valid),
    .s_data               (s_data),
    .s_ready              (s_ready),
    .enc_rst_n            (enc_rst_n),
    .enc_din_valid        (enc_din_valid),
    .enc_din              (enc_din),
    .enc_counter          (enc_counter),
    .enc_out_addr         (enc_out_addr),
    .enc_data_valid_check (enc_data_valid_check),
    .enc_dout             (enc_dout),
    .m_valid              (m_valid),
    .m_data               (m_data),
    .m_sof                (m_sof),
    .m_eof                (m_eof),
    .frame_done           (frame_done)
  );

  typedef struct packed {
    logic d;
    logic sof;
    logic eof;
  } exp_t;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t q[$];
  exp_t e;
  logic frm_data [K_BITS];

  int cyc = 0, ready_run = 0, last_low = 0, park_events = 0;
  int eof_count = 0, beats = 0, sof_cyc = 0, last_len = 0, last_span = 0;
  logic [CNT_W-1:0] prev_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Each information bit toggles two parity positions chosen by group and offset
  function automatic logic [GROUP-1:0] row_mask(input int idx);
    int j = idx % GROUP;
    int g = idx / GROUP;
    logic [GROUP-1:0] m = '0;
    m[j] = ~m[j];
    m[(j * 37 + g * 11 + 1) % GROUP] = ~m[(j * 37 + g * 11 + 1) % GROUP];
    return m;
  endfunction

  function automatic logic [GROUP-1:0] gold();
    logic [GROUP-1:0] p = '0;
    for (int i = 0; i < int'(K_BITS); i++)
      if (frm_data[i]) p = p ^ row_mask(i);
    return p;
  endfunction

  // Encoder stub: sync clear, accumulate on strobe, registered parity read
  logic [GROUP-1:0] acc = '0;
  always @(posedge clk) begin
    if (!enc_rst_n) acc <= '0;
    else if (enc_din_valid && enc_din && enc_counter < CNT_PARK)
      acc <= acc ^ row_mask(int'(enc_counter));
    enc_dout <= acc[enc_out_addr];
  end

  // Output monitor and phase checks
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (!s_ready) ready_run++;
      else begin
        if (ready_run > 0) last_low = ready_run;
        ready_run = 0;
      end
      if (enc_counter == CNT_PARK && prev_cnt != CNT_PARK) park_events++;
      prev_cnt = enc_counter;
      if (!enc_rst_n)
        chk("clear_quiet", {28'd0, s_ready, enc_din_valid, enc_data_valid_check,
                            enc_counter != '0}, 32'd0);
      if (enc_data_valid_check)
        chk("parity_exclusive", {30'd0, s_ready, enc_din_valid}, 32'd0);
      if (m_valid) begin
        if (q.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("m_data", {31'd0, m_data}, {31'd0, e.d});
          chk("m_sof", {31'd0, m_sof}, {31'd0, e.sof});
          chk("m_eof", {31'd0, m_eof}, {31'd0, e.eof});
          chk("frame_done", {31'd0, frame_done}, {31'd0, e.eof});
        end
        if (m_sof) begin
          sof_cyc = cyc;
          beats   = 0;
        end
        beats++;
        if (m_eof) begin
          last_len  = beats;
          last_span = cyc - sof_cyc;
          eof_count++;
        end
      end else begin
        chk("idle_flags", {29'd0, m_sof, m_eof, frame_done}, 32'd0);
      end
    end
  end

  task automatic gen(input int mode);
    for (int i = 0; i < int'(K_BITS); i++)
      frm_data[i] = (mode == 0) ? 1'b0 : (mode == 1) ? (i == 0) : 1'($urandom_range(1));
  endtask

  task automatic send_frame(input int idle_pct, input bit force_stall);
    int i = 0, t = 0, hold = 0, prev_i = -1;
    bit stall;
    logic [GROUP-1:0] p;
    park_events = 0;
    while (i < int'(K_BITS) && t < 20000) begin
      @(negedge clk); #1;
      t++;
      if (i != prev_i) begin
        hold   = 0;
        prev_i = i;
      end
      stall = (force_stall && (i == 356 || i == 359 || i == 4319) && hold < 3) ||
              ($urandom_range(99) < idle_pct);
      if (stall) hold++;
      s_valid = !stall;
      s_data  = stall ? 1'($urandom_range(1)) : frm_data[i];
      if (s_valid && s_ready) begin
        q.push_back('{frm_data[i], (i == 0), 1'b0});
        if (i == int'(K_BITS) - 1) begin
          p = gold();
          for (int a = int'(GROUP) - 1; a >= 0; a--)
            q.push_back('{p[a], 1'b0, (a == 0)});
        end
        i++;
      end
    end
    chk("send_complete", i, K_BITS);
    @(negedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_frame();
    int t = 0;
    int start = eof_count;
    while (eof_count == start && t < 2000) begin
      @(negedge clk); #2;
      t++;
    end
    chk("frame_end_seen", eof_count, start + 1);
    chk("frame_beats", last_len, K_BITS + GROUP);
    chk("park_once", park_events, 1);
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!s_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int eofs;
    rst = 1'b1; s_valid = 1'b0; s_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enc_rst_n", {31'd0, enc_rst_n}, 32'd0);
    chk("rst_ctrl", {27'd0, s_ready, enc_din_valid, enc_din, enc_data_valid_check, m_valid}, 32'd0);
    chk("rst_counter", {19'd0, enc_counter}, 32'd0);
    chk("rst_addr", {23'd0, enc_out_addr}, 32'd0);
    chk("rst_flags", {29'd0, m_sof, m_eof, frame_done}, 32'd0);
    @(negedge clk); #2;
    rst = 1'b0;
    wait_ready(n);
    chk("clear_len_after_reset", n, CLR_CYCLES);

    // all-zero, gap-free
    gen(0); send_frame(0, 1'b0); wait_frame();
    chk("frame_span_gapfree", last_span, K_BITS + GROUP);

    // single 1 at index 0, back-to-back
    gen(1); send_frame(0, 1'b0);
    chk("ready_low_between", last_low, GROUP + 1 + CLR_CYCLES);
    wait_frame();

    // random data with gaps and boundary stalls, then same data gap-free
    gen(2); send_frame(30, 1'b1);
    chk("ready_low_between", last_low, GROUP + 1 + CLR_CYCLES);
    wait_frame();
    send_frame(0, 1'b0);
    chk("ready_low_between", last_low, GROUP + 1 + CLR_CYCLES);
    wait_frame();
    chk("frame_span_gapfree", last_span, K_BITS + GROUP);

    // fresh random frame right after: clear must isolate frames
    gen(2); send_frame(10, 1'b0);
    chk("ready_low_between", last_low, GROUP + 1 + CLR_CYCLES);
    wait_frame();

    // reset in the middle of the parity sweep
    gen(2); send_frame(0, 1'b0);
    n = 0;
    while (!(enc_data_valid_check && enc_out_addr == 9'd200) && n < 1000) begin
      @(negedge clk); #2;
      n++;
    end
    chk("reached_addr_200", {23'd0, enc_out_addr}, 32'd200);
    eofs = eof_count;
    rst = 1'b1;
    #1;
    chk("midrst_enc_rst_n", {31'd0, enc_rst_n}, 32'd0);
    chk("midrst_ctrl", {26'd0, s_ready, enc_din_valid, enc_din, enc_data_valid_check,
                        m_valid, m_data}, 32'd0);
    chk("midrst_counter_addr", {10'd0, enc_counter, enc_out_addr}, 32'd0);
    chk("midrst_flags", {29'd0, m_sof, m_eof, frame_done}, 32'd0);
    q.delete();
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    wait_ready(n);
    chk("clear_len_after_midrst", n, CLR_CYCLES);
    chk("no_eof_abandoned", eof_count, eofs);

    gen(2); send_frame(0, 1'b0); wait_frame();
    chk("frame_span_after_reset", last_span, K_BITS + GROUP);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ldpc_enc_ctrl.md
# ldpc_enc_ctrl

Frame sequencer for the 4320-bit-information / 360-bit-parity LDPC encoder datapath. It accepts a serial information stream with a valid/ready handshake and feeds the encoder one bit per cycle, generating the bit index that drives the encoder's generator-ROM group selection. It clears the encoder between frames, then sweeps the parity read address from 359 down to 0. It merges systematic and parity bits into one framed serial output toward the modulator.

## Interface
- K_BITS, 4320, information bits per frame (12 groups of GROUP)
- GROUP, 360, circulant size = parity bits per frame
- CLR_CYCLES, 3, encoder clear length (covers ROM address register + ROM read latency)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  information bit present
- s_data  in  1  information bit
- s_ready  out  1  controller accepts s_data this cycle
- enc_rst_n  out  1  synchronous active-low clear to encoder
- enc_din_valid  out  1  encoder bit strobe
- enc_din  out  1  encoder bit
- enc_counter  out  13  index of presented bit
- enc_out_addr  out  9  parity bit select
- enc_data_valid_check  out  1  parity read enable
- enc_dout  in  1  encoder parity bit (registered in encoder, 1-cycle latency from enc_out_addr)
- m_valid  out  1  output bit valid (no backpressure)
- m_data  out  1  output bit
- m_sof  out  1  first systematic bit of frame
- m_eof  out  1  last parity bit of frame
- frame_done  out  1  one-cycle pulse coincident with m_eof

## Operation
- States: CLEAR → LOAD → PARITY → CLEAR.
- CLEAR: lasts CLR_CYCLES cycles.
  - enc_rst_n=0, enc_counter=0, s_ready=0.
  - Zeroes the encoder parity accumulator and preloads the group-0 ROM row.
- LOAD: s_ready=1.
  - On s_valid&s_ready, register enc_din_valid=1, enc_din=s_data, enc_counter=bit index (0..K_BITS−1).
  - Without acceptance, enc_din_valid=0 and enc_counter holds its last value. Held values are harmless because the encoder acts only on enc_din_valid.
  - The cycle after index K_BITS−1 is presented, enc_counter parks at 4320. This keeps the encoder's finish pulse to exactly one.
  - s_ready drops in the cycle after the last accept.
- PARITY: 360 cycles.
  - enc_data_valid_check=1; enc_out_addr=359,358,…,0, one per cycle.
  - Afterwards enc_data_valid_check=0, enc_out_addr=0, then CLEAR.
- Systematic output: m_valid=enc_din_valid, m_data=enc_din (same registers), m_sof with index 0.
- Parity output: m_valid = enc_data_valid_check delayed by 1 cycle; m_data=enc_dout combinationally.
  - m_eof and frame_done fire with the bit read at address 0.
- Per frame: exactly 4680 m_valid beats, systematic first, parity MSB-address first.
- The encoder's calculate_finish is not used; the controller derives completion from its own counters.

## Timing
- Reset: state CLEAR (count restarts), enc_rst_n=0, all other outputs 0, enc_counter=0.
- Reset mid-frame abandons the frame; no m_eof is issued for it.
- Accept at edge E lands on enc_din/m_data in the cycle after E, giving 1-cycle input-to-output latency.
- Last bit presented in cycle T:
  - PARITY addresses occupy T+1..T+360.
  - Parity m_valid occupies T+2..T+361; m_eof at T+361.
  - CLEAR covers T+361..T+360+CLR_CYCLES.
  - s_ready returns at T+361+CLR_CYCLES.
- Gap-free input yields 4320 consecutive systematic beats, then 1 idle cycle, then 360 parity beats.
- Input stalls anywhere in LOAD (including at index 356–359 group boundaries and at 4319) only stretch the frame; the parity result is unchanged.
- No simultaneous events are possible between input and parity phases: s_ready=0 throughout PARITY and CLEAR.

## Structure
- Shared package: K_BITS, GROUP, CLR_CYCLES, the 13-bit counter park value 4320, and the state enum.
- Sub-module: none beyond the encoder itself.
- Optional top-level `ldpc_enc_top` instantiates ldpc_enc_ctrl plus encoder1.

## Test plan
- Reset, then all-zero frame with s_valid=1 continuous → 4320 zero systematic beats, 1 idle cycle, 360 zero parity beats, single m_eof/frame_done at beat 4680.
- Single 1 at index 0, rest 0 → parity equals ROM group-0 row output in address order 359..0; compare to golden model.
- Random frame with random s_valid gaps (30% idle), including stalls while index 359 and 4319 are pending → parity identical to the gap-free run of the same data; enc_counter reaches 4320 exactly once per frame.
- Two back-to-back random frames → second frame's parity is independent of the first (clear verified); s_ready low for exactly 361+CLR_CYCLES cycles between frames.
- Assert rst during PARITY at address 200 → all outputs 0 immediately, no m_eof; next frame encodes correctly.
- Monitor: enc_din_valid never high outside LOAD, enc_data_valid_check never high outside PARITY, enc_rst_n low only in CLEAR.
